// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine change controller:
// coin values, item codes, completion status codes, the sequencer
// state encoding and the one-hot product-release encodings.
package vend_pkg;

    localparam int unsigned COIN_10 = 10;
    localparam int unsigned COIN_20 = 20;
    localparam int unsigned COIN_50 = 50;

    typedef enum logic [1:0] {
        ITEM_MAZA    = 2'd0,
        ITEM_FANTA   = 2'd1,
        ITEM_COLA    = 2'd2,
        ITEM_INVALID = 2'd3
    } item_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_UNDERPAID = 2'd1,
        ST_NOCHANGE  = 2'd2,
        ST_INVALID   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EJECT,
        S_GAP,
        S_VEND,
        S_DONE
    } state_e;

    localparam logic [2:0] VEND_MAZA  = 3'b001;
    localparam logic [2:0] VEND_FANTA = 3'b010;
    localparam logic [2:0] VEND_COLA  = 3'b100;

    function automatic logic [2:0] vend_onehot(input item_e item);
        case (item)
            ITEM_MAZA:  return VEND_MAZA;
            ITEM_FANTA: return VEND_FANTA;
            ITEM_COLA:  return VEND_COLA;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_controller_if.sv
// Request/actuator bundle of the change controller.
//   master : front panel / note acceptor side (drives the request and refill)
//   slave  : vend_change_controller (drives ejectors, vend, escrow, status)
// Signals:
//   i_req_valid/o_req_ready  request handshake
//   i_paid, i_price, i_item  request payload
//   i_refill                 inventory refill pulse
//   o_eject_{fifty,twenty,ten} coin ejector drives
//   o_vend                   one-hot product release pulse
//   o_escrow_accept/return   note escrow pulses
//   o_done, o_status         completion pulse and status
//   o_busy                   transaction in progress
interface vend_change_controller_if #(
    parameter int unsigned AMT_W = 8
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic [AMT_W-1:0] i_paid;
    logic [AMT_W-1:0] i_price;
    logic [1:0]       i_item;
    logic             i_refill;
    logic             o_eject_fifty;
    logic             o_eject_twenty;
    logic             o_eject_ten;
    logic [2:0]       o_vend;
    logic             o_escrow_accept;
    logic             o_escrow_return;
    logic             o_done;
    logic [1:0]       o_status;
    logic             o_busy;

    modport master (
        output i_req_valid, i_paid, i_price, i_item, i_refill,
        input  o_req_ready, o_eject_fifty, o_eject_twenty, o_eject_ten,
               o_vend, o_escrow_accept, o_escrow_return, o_done,
               o_status, o_busy
    );

    modport slave (
        input  i_req_valid, i_paid, i_price, i_item, i_refill,
        output o_req_ready, o_eject_fifty, o_eject_twenty, o_eject_ten,
               o_vend, o_escrow_accept, o_escrow_return, o_done,
               o_status, o_busy
    );

endinterface

// File: rtl/vend_change_plan.sv
// Combinational greedy change planner (50, then 20, then 10).
// Each coin count is min(remaining / coin, inventory); the change is
// feasible only if nothing remains after the 10-coin step.
// Ports:
//   i_change                 change to return
//   i_inv50/i_inv20/i_inv10  coin inventories
//   o_feasible               plan covers the change exactly
//   o_n50/o_n20/o_n10        planned coin counts
module vend_change_plan
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W = 8,
    parameter int unsigned INV_W = 4
) (
    input  logic [AMT_W-1:0] i_change,
    input  logic [INV_W-1:0] i_inv50,
    input  logic [INV_W-1:0] i_inv20,
    input  logic [INV_W-1:0] i_inv10,
    output logic             o_feasible,
    output logic [INV_W-1:0] o_n50,
    output logic [INV_W-1:0] o_n20,
    output logic [INV_W-1:0] o_n10
);

    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] quo;

    always_comb begin
        rem = i_change;

        quo = rem / AMT_W'(COIN_50);
        o_n50 = (quo > AMT_W'(i_inv50)) ? i_inv50 : INV_W'(quo);
        rem = rem - AMT_W'(o_n50) * AMT_W'(COIN_50);

        quo = rem / AMT_W'(COIN_20);
        o_n20 = (quo > AMT_W'(i_inv20)) ? i_inv20 : INV_W'(quo);
        rem = rem - AMT_W'(o_n20) * AMT_W'(COIN_20);

        quo = rem / AMT_W'(COIN_10);
        o_n10 = (quo > AMT_W'(i_inv10)) ? i_inv10 : INV_W'(quo);
        rem = rem - AMT_W'(o_n10) * AMT_W'(COIN_10);

        o_feasible = (rem == '0);
    end

endmodule

// File: rtl/vend_change_controller.sv
// Vending transaction sequencer: accepts one purchase, validates payment
// and change availability, ejects change one coin at a time with timed
// pulses, releases the product and escrow, then reports status.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    request / actuator bundle (slave side)
module vend_change_controller
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W     = 8,
    parameter int unsigned INV_W     = 4,
    parameter int unsigned INIT_INV  = 4,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    vend_change_controller_if.slave  bus
);

    localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q,  state_d;
    logic [AMT_W-1:0] paid_q,   paid_d;
    logic [AMT_W-1:0] price_q,  price_d;
    item_e            item_q,   item_d;
    logic [AMT_W-1:0] rem_q,    rem_d;
    logic [INV_W-1:0] inv50_q,  inv50_d;
    logic [INV_W-1:0] inv20_q,  inv20_d;
    logic [INV_W-1:0] inv10_q,  inv10_d;
    logic [INV_W-1:0] n50_q,    n50_d;
    logic [INV_W-1:0] n20_q,    n20_d;
    logic [INV_W-1:0] n10_q,    n10_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    status_e          status_q, status_d;

    logic             invalid;
    logic             underpaid;
    logic [AMT_W-1:0] change;
    logic             plan_ok;
    logic [INV_W-1:0] plan_n50, plan_n20, plan_n10;
    logic             pulse_last;
    logic             gap_last;

    assign invalid   = (item_q == ITEM_INVALID)
                     || ((paid_q  % AMT_W'(COIN_10)) != '0)
                     || ((price_q % AMT_W'(COIN_10)) != '0);
    assign underpaid = (paid_q < price_q);
    assign change    = underpaid ? '0 : (paid_q - price_q);

    vend_change_plan #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_plan (
        .i_change   (change),
        .i_inv50    (inv50_q),
        .i_inv20    (inv20_q),
        .i_inv10    (inv10_q),
        .o_feasible (plan_ok),
        .o_n50      (plan_n50),
        .o_n20      (plan_n20),
        .o_n10      (plan_n10)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            paid_q   <= '0;
            price_q  <= '0;
            item_q   <= ITEM_MAZA;
            rem_q    <= '0;
            inv50_q  <= INV_W'(INIT_INV);
            inv20_q  <= INV_W'(INIT_INV);
            inv10_q  <= INV_W'(INIT_INV);
            n50_q    <= '0;
            n20_q    <= '0;
            n10_q    <= '0;
            cnt_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            paid_q   <= paid_d;
            price_q  <= price_d;
            item_q   <= item_d;
            rem_q    <= rem_d;
            inv50_q  <= inv50_d;
            inv20_q  <= inv20_d;
            inv10_q  <= inv10_d;
            n50_q    <= n50_d;
            n20_q    <= n20_d;
            n10_q    <= n10_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paid_d   = paid_q;
        price_d  = price_q;
        item_d   = item_q;
        rem_d    = rem_q;
        inv50_d  = inv50_q;
        inv20_d  = inv20_q;
        inv10_d  = inv10_q;
        n50_d    = n50_q;
        n20_d    = n20_q;
        n10_d    = n10_q;
        cnt_d    = cnt_q;
        status_d = status_q;

        pulse_last = (cnt_q == CNT_W'(PULSE_CYC - 1));
        gap_last   = (cnt_q == CNT_W'(GAP_CYC - 1));

        bus.o_req_ready     = 1'b0;
        bus.o_eject_fifty   = 1'b0;
        bus.o_eject_twenty  = 1'b0;
        bus.o_eject_ten     = 1'b0;
        bus.o_vend          = 3'b000;
        bus.o_escrow_accept = 1'b0;
        bus.o_escrow_return = 1'b0;
        bus.o_done          = 1'b0;
        bus.o_status        = 2'b00;
        bus.o_busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Ready is held low while reset is asserted.
                bus.o_req_ready = !i_rst;
                if (bus.i_refill) begin
                    inv50_d = '1;
                    inv20_d = '1;
                    inv10_d = '1;
                end
                if (bus.i_req_valid) begin
                    paid_d  = bus.i_paid;
                    price_d = bus.i_price;
                    item_d  = item_e'(bus.i_item);
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                cnt_d = '0;
                if (invalid) begin
                    status_d            = ST_INVALID;
                    bus.o_escrow_return = 1'b1;
                    state_d             = S_DONE;
                end else if (underpaid) begin
                    status_d            = ST_UNDERPAID;
                    bus.o_escrow_return = 1'b1;
                    state_d             = S_DONE;
                end else if (!plan_ok) begin
                    status_d            = ST_NOCHANGE;
                    bus.o_escrow_return = 1'b1;
                    state_d             = S_DONE;
                end else begin
                    status_d = ST_OK;
                    rem_d    = change;
                    n50_d    = plan_n50;
                    n20_d    = plan_n20;
                    n10_d    = plan_n10;
                    state_d  = (change != '0) ? S_EJECT : S_VEND;
                end
            end

            S_EJECT: begin
                // Walking the stored plan largest-first picks the same coin
                // as "largest coin <= rem with stock", and cannot stall.
                cnt_d = pulse_last ? '0 : cnt_q + CNT_W'(1);
                if (pulse_last) begin
                    state_d = S_GAP;
                end
                if (n50_q != '0) begin
                    bus.o_eject_fifty = 1'b1;
                    if (pulse_last) begin
                        rem_d   = rem_q - AMT_W'(COIN_50);
                        inv50_d = inv50_q - INV_W'(1);
                        n50_d   = n50_q - INV_W'(1);
                    end
                end else if (n20_q != '0) begin
                    bus.o_eject_twenty = 1'b1;
                    if (pulse_last) begin
                        rem_d   = rem_q - AMT_W'(COIN_20);
                        inv20_d = inv20_q - INV_W'(1);
                        n20_d   = n20_q - INV_W'(1);
                    end
                end else if (n10_q != '0) begin
                    bus.o_eject_ten = 1'b1;
                    if (pulse_last) begin
                        rem_d   = rem_q - AMT_W'(COIN_10);
                        inv10_d = inv10_q - INV_W'(1);
                        n10_d   = n10_q - INV_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_VEND;
                end
            end

            S_GAP: begin
                cnt_d = gap_last ? '0 : cnt_q + CNT_W'(1);
                if (gap_last) begin
                    state_d = (rem_q != '0) ? S_EJECT : S_VEND;
                end
            end

            S_VEND: begin
                bus.o_vend          = vend_onehot(item_q);
                bus.o_escrow_accept = 1'b1;
                state_d             = S_DONE;
            end

            S_DONE: begin
                bus.o_done   = 1'b1;
                bus.o_status = status_q;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
